// File: rtl/fcl_fp_pkg.sv
// Shared constants, default sizing and FSM state type for the fixed-point
// fully-connected sequencer and its helpers.
package fcl_fp_pkg;

  localparam int unsigned FP_WIDTH      = 16;
  localparam int unsigned FP_PARALLEL   = 8;
  localparam int unsigned SHIFT_W       = 6;

  localparam int unsigned DEF_MAX_IN    = 1024;
  localparam int unsigned DEF_MAX_TILES = 128;
  localparam int unsigned DEF_MEM_LAT   = 1;

  // Counter / address widths for the default sizing.
  localparam int unsigned LEN_W   = $clog2(DEF_MAX_IN + 1);
  localparam int unsigned TILES_W = $clog2(DEF_MAX_TILES + 1);
  localparam int unsigned K_W     = $clog2(DEF_MAX_IN);
  localparam int unsigned TILE_W  = $clog2(DEF_MAX_TILES);
  localparam int unsigned WADDR_W = $clog2(DEF_MAX_IN * DEF_MAX_TILES);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN,
    PRESENT,
    FIN
  } state_e;

endpackage

// File: rtl/fcl_fp_ctrl_dly.sv
// DEPTH-stage shift register carrying {valid, first} so array controls line up
// with data returning from the operand memories.
module fcl_fp_ctrl_dly #(
  parameter int unsigned DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic valid_i,
  input  logic first_i,
  output logic valid_o,
  output logic first_o
);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic [1:0] q;
      if (gi == 0) begin : g_head
        always_ff @(posedge clk) begin
          if (rst) q <= 2'b00;
          else     q <= {valid_i, first_i};
        end
      end else begin : g_tail
        always_ff @(posedge clk) begin
          if (rst) q <= 2'b00;
          else     q <= g_stage[gi-1].q;
        end
      end
    end
  endgenerate

  assign valid_o = g_stage[DEPTH-1].q[1];
  assign first_o = g_stage[DEPTH-1].q[0];

endmodule

// File: rtl/fcl_fp_ctrl.sv
// Tile sequencer for the fixed-point FC PE array: issues operand reads,
// steers load/accumulate/zero-gating and presents each finished tile.
module fcl_fp_ctrl #(
  parameter int unsigned MAX_IN    = fcl_fp_pkg::DEF_MAX_IN,
  parameter int unsigned MAX_TILES = fcl_fp_pkg::DEF_MAX_TILES,
  parameter int unsigned MEM_LAT   = fcl_fp_pkg::DEF_MEM_LAT,
  parameter int unsigned SHIFT_W   = fcl_fp_pkg::SHIFT_W
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic [$clog2(MAX_IN+1)-1:0]            in_len,
  input  logic [$clog2(MAX_TILES+1)-1:0]         out_tiles,
  input  logic [SHIFT_W-1:0]                     shift_cfg,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   err,
  output logic                                   rd_en,
  output logic [$clog2(MAX_IN)-1:0]              in_addr,
  output logic [$clog2(MAX_IN*MAX_TILES)-1:0]    w_addr,
  output logic                                   pe_rst_n,
  output logic                                   pe_zero,
  output logic [SHIFT_W-1:0]                     pe_shift,
  output logic                                   out_valid,
  output logic [$clog2(MAX_TILES)-1:0]           out_tile,
  input  logic                                   out_ready
);

  import fcl_fp_pkg::*;

  localparam int unsigned LW  = $clog2(MAX_IN + 1);
  localparam int unsigned TSW = $clog2(MAX_TILES + 1);
  localparam int unsigned KW  = $clog2(MAX_IN);
  localparam int unsigned TW  = $clog2(MAX_TILES);
  localparam int unsigned WAW = $clog2(MAX_IN * MAX_TILES);
  localparam int unsigned DRW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  state_e          state_q;
  logic [KW-1:0]   k_q;
  logic [WAW-1:0]  base_q;
  logic [WAW-1:0]  w_addr_q;
  logic [TW-1:0]   tile_q;
  logic [LW-1:0]   len_q;
  logic [TSW-1:0]  tiles_q;
  logic [SHIFT_W-1:0] shift_q;
  logic [DRW-1:0]  drain_q;
  logic            busy_q, done_q, err_q, rd_en_q, out_valid_q;

  logic            cfg_zero, last_k, last_tile, drain_end;
  logic [WAW-1:0]  base_d;
  logic            dly_valid, dly_first;

  assign cfg_zero  = (in_len == '0) || (out_tiles == '0);
  assign last_k    = (LW'(k_q) == len_q - LW'(1));
  assign last_tile = (TSW'(tile_q) == tiles_q - TSW'(1));
  assign drain_end = (drain_q == DRW'(MEM_LAT - 1));
  // Running row base replaces tile*in_len.
  assign base_d    = base_q + WAW'(len_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      base_q      <= '0;
      w_addr_q    <= '0;
      tile_q      <= '0;
      len_q       <= '0;
      tiles_q     <= '0;
      shift_q     <= '0;
      drain_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rd_en_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            len_q    <= in_len;
            tiles_q  <= out_tiles;
            shift_q  <= shift_cfg;
            k_q      <= '0;
            base_q   <= '0;
            w_addr_q <= '0;
            tile_q   <= '0;
            busy_q   <= 1'b1;
            if (cfg_zero) begin
              state_q <= FIN;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              state_q <= ISSUE;
              rd_en_q <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (last_k) begin
            state_q <= DRAIN;
            rd_en_q <= 1'b0;
            drain_q <= '0;
          end else begin
            k_q      <= k_q + KW'(1);
            w_addr_q <= w_addr_q + WAW'(1);
          end
        end
        DRAIN: begin
          if (drain_end) begin
            state_q     <= PRESENT;
            out_valid_q <= 1'b1;
          end else begin
            drain_q <= drain_q + DRW'(1);
          end
        end
        PRESENT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (last_tile) begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end else begin
              state_q  <= ISSUE;
              rd_en_q  <= 1'b1;
              k_q      <= '0;
              tile_q   <= tile_q + TW'(1);
              base_q   <= base_d;
              w_addr_q <= base_d;
            end
          end
        end
        FIN: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  fcl_fp_ctrl_dly #(
    .DEPTH (MEM_LAT)
  ) u_dly (
    .clk     (clk),
    .rst     (rst),
    .valid_i (rd_en_q),
    .first_i (rd_en_q && (k_q == '0)),
    .valid_o (dly_valid),
    .first_o (dly_first)
  );

  // First product of a tile overwrites the accumulator; idle cycles hold it.
  assign pe_zero   = !dly_valid;
  assign pe_rst_n  = !(dly_valid && dly_first);

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign rd_en     = rd_en_q;
  assign in_addr   = k_q;
  assign w_addr    = w_addr_q;
  assign pe_shift  = shift_q;
  assign out_valid = out_valid_q;
  assign out_tile  = tile_q;

endmodule

// File: tb/tb_fcl_fp_ctrl.sv
// Bench for fcl_fp_ctrl: models operand memories plus a 4-lane accumulator
// array and checks sequencing, addressing, alignment and handshakes.
module tb_fcl_fp_ctrl;
  import fcl_fp_pkg::*;

  localparam int LANES = 4;
  localparam int LAT   = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [LEN_W-1:0]   in_len = '0;
  logic [TILES_W-1:0] out_tiles = '0;
  logic [SHIFT_W-1:0] shift_cfg = '0;
  logic out_ready = 1'b0;
  logic busy, done, err, rd_en, pe_rst_n, pe_zero, out_valid;
  logic [K_W-1:0]     in_addr;
  logic [WADDR_W-1:0] w_addr;
  logic [SHIFT_W-1:0] pe_shift;
  logic [TILE_W-1:0]  out_tile;

  always #5 clk = ~clk;

  fcl_fp_ctrl #(
    .MEM_LAT (LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_len    (in_len),
    .out_tiles (out_tiles),
    .shift_cfg (shift_cfg),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .rd_en     (rd_en),
    .in_addr   (in_addr),
    .w_addr    (w_addr),
    .pe_rst_n  (pe_rst_n),
    .pe_zero   (pe_zero),
    .pe_shift  (pe_shift),
    .out_valid (out_valid),
    .out_tile  (out_tile),
    .out_ready (out_ready)
  );

  // Operand memories (one-cycle read) and the accumulating array.
  logic [7:0]  act_mem [0:1023];
  logic [7:0]  w_mem   [0:1023][0:LANES-1];
  logic [7:0]  act_rd = '0;
  logic [7:0]  w_rd    [0:LANES-1];
  logic [31:0] acc     [0:LANES-1];

  always @(posedge clk) begin
    if (rd_en) begin
      act_rd <= act_mem[in_addr];
      for (int l = 0; l < LANES; l++) w_rd[l] <= w_mem[w_addr[9:0]][l];
    end
  end

  always @(posedge clk) begin
    for (int l = 0; l < LANES; l++)
      acc[l] <= (pe_rst_n ? acc[l] : 32'd0) +
                (pe_zero ? 32'd0 : 32'(act_rd) * 32'(w_rd[l]));
  end

  int n_checks = 0;
  int n_errors = 0;
  int exp_sum [0:15][0:LANES-1];

  task automatic chk(input string name, input longint got, input longint want);
    n_checks++;
    if (got != want) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic fill_mem(input bit basic);
    for (int i = 0; i < 1024; i++) begin
      act_mem[i] = basic ? 8'd2 : 8'($urandom_range(0, 255));
      for (int l = 0; l < LANES; l++)
        w_mem[i][l] = basic ? 8'(l + 1) : 8'($urandom_range(0, 255));
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_rd_en"}, rd_en, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_pe_rst_n"}, pe_rst_n, 1);
    chk({tag, "_pe_zero"}, pe_zero, 1);
    chk({tag, "_in_addr"}, in_addr, 0);
    chk({tag, "_w_addr"}, w_addr, 0);
    chk({tag, "_out_tile"}, out_tile, 0);
    chk({tag, "_pe_shift"}, pe_shift, 0);
  endtask

  // Runs one layer from the start pulse to done; stall<0 picks a random
  // backpressure per tile, poke re-pulses start with altered config mid-layer.
  task automatic run_layer(input int len, input int tiles, input int shift,
                           input int stall, input bit poke,
                           output int done_cyc, output int err_seen, output int nreads);
    int exp_k[$];
    int exp_w[$];
    int cyc, tile, tile_start, pres_cnt, want_stall, hs_last, hs_count, k, w;
    bit prev_rd, prev_k0, in_present;
    for (int t = 0; t < tiles; t++) begin
      for (int i = 0; i < len; i++) begin
        exp_k.push_back(i);
        exp_w.push_back(t * len + i);
      end
      for (int l = 0; l < LANES; l++) begin
        exp_sum[t][l] = 0;
        for (int i = 0; i < len; i++)
          exp_sum[t][l] += int'(act_mem[i]) * int'(w_mem[t * len + i][l]);
      end
    end
    done_cyc = -1; err_seen = 0; nreads = 0;
    tile = 0; tile_start = 1; hs_last = 0; hs_count = 0;
    prev_rd = 0; prev_k0 = 0; in_present = 0; pres_cnt = 0; want_stall = 0;
    @(negedge clk);
    in_len = LEN_W'(len); out_tiles = TILES_W'(tiles); shift_cfg = SHIFT_W'(shift);
    start = 1'b1; out_ready = 1'b0;
    cyc = 0;
    while (done_cyc < 0 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      out_ready = 1'b0;
      if (poke && cyc == 2) begin
        start = 1'b1;
        in_len = LEN_W'(len + 5);
        out_tiles = TILES_W'(tiles + 1);
        shift_cfg = SHIFT_W'(shift ^ 1);
      end
      chk("busy", busy, 1);
      chk("pe_shift", pe_shift, shift);
      chk("pe_zero", pe_zero, !prev_rd);
      chk("pe_rst_n", pe_rst_n, !(prev_rd && prev_k0));
      if (rd_en) begin
        nreads++;
        chk("read_during_valid", out_valid, 0);
        if (exp_k.size() == 0) chk("extra_read", nreads, nreads - 1);
        else begin
          k = exp_k.pop_front();
          w = exp_w.pop_front();
          chk("in_addr", in_addr, k);
          chk("w_addr", w_addr, w);
          if (k == 0) chk("first_read_cycle", cyc, tile_start);
        end
      end
      prev_rd = rd_en;
      prev_k0 = (in_addr == 0);
      if (out_valid) begin
        if (!in_present) begin
          in_present = 1;
          pres_cnt = 0;
          want_stall = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
          chk("valid_rise_cycle", cyc, tile_start + len + LAT);
        end
        chk("out_tile", out_tile, tile);
        if (tile < tiles) begin
          for (int l = 0; l < LANES; l++) chk("tile_output", acc[l], exp_sum[tile][l]);
        end else chk("extra_tile", tile, tiles - 1);
        if (pres_cnt == want_stall) begin
          out_ready = 1'b1;
          $display("tile %0d accepted at cycle %0d", tile, cyc);
          hs_count++;
          hs_last = cyc;
          tile++;
          tile_start = cyc + 1;
          in_present = 0;
        end else pres_cnt++;
      end
      if (done) begin
        done_cyc = cyc;
        err_seen = int'(err);
      end
    end
    if (done_cyc < 0) chk("done_timeout", 0, 1);
    chk("reads_left", exp_k.size(), 0);
    chk("handshakes", hs_count, (len > 0 && tiles > 0) ? tiles : 0);
    if (hs_count > 0) chk("done_after_handshake", done_cyc, hs_last + 1);
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_done", done, 0);
    chk("post_busy", busy, 0);
    chk("post_rd_en", rd_en, 0);
    $display("layer len=%0d tiles=%0d done at cycle %0d err=%0d reads=%0d",
             len, tiles, done_cyc, err_seen, nreads);
  endtask

  typedef struct {
    int len;
    int tiles;
    int shift;
    int stall;
    bit poke;
    bit basic;
    int exp_done;
    int exp_err;
    int exp_reads;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int dc, es, nr, n;
    vecs[0] = '{3, 1, 0,  0, 1'b0, 1'b1,  6, 0,  3};  // basic tile
    vecs[1] = '{4, 3, 3,  0, 1'b0, 1'b0, 19, 0, 12};  // multi-tile addressing
    vecs[2] = '{4, 2, 9, 10, 1'b0, 1'b0, 33, 0,  8};  // backpressure
    vecs[3] = '{0, 2, 1,  0, 1'b0, 1'b0,  1, 1,  0};  // zero in_len
    vecs[4] = '{3, 0, 2,  0, 1'b0, 1'b0,  1, 1,  0};  // zero out_tiles
    vecs[5] = '{5, 2, 4,  1, 1'b1, 1'b0, 17, 0, 10};  // start/config while busy
    vecs[6] = '{1, 4, 63, 0, 1'b0, 1'b0, 13, 0,  4};  // single-activation tiles

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      fill_mem(vecs[i].basic);
      run_layer(vecs[i].len, vecs[i].tiles, vecs[i].shift, vecs[i].stall,
                vecs[i].poke, dc, es, nr);
      chk("vec_done_cycle", dc, vecs[i].exp_done);
      chk("vec_err", es, vecs[i].exp_err);
      chk("vec_reads", nr, vecs[i].exp_reads);
      if (i == 0) begin
        for (int l = 0; l < LANES; l++) chk("basic_output", acc[l], 6 * (l + 1));
      end
    end

    // Reset during the second tile's reads, then a clean layer.
    fill_mem(1'b0);
    @(negedge clk);
    in_len = LEN_W'(4); out_tiles = TILES_W'(3); shift_cfg = SHIFT_W'(5); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (!(rd_en && w_addr == WADDR_W'(5)) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("midrst_reached_tile1", n < 50, 1);
    rst = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    check_idle("midrst");
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("midrst_no_done", done, 0);
      chk("midrst_no_read", rd_en, 0);
    end
    run_layer(4, 3, 7, 0, 1'b0, dc, es, nr);
    chk("after_rst_done_cycle", dc, 19);
    chk("after_rst_reads", nr, 12);

    for (int r = 0; r < 8; r++) begin
      int len, tiles, shift;
      len = int'($urandom_range(1, 12));
      tiles = int'($urandom_range(1, 5));
      shift = int'($urandom_range(0, 63));
      fill_mem(1'b0);
      run_layer(len, tiles, shift, -1, 1'b0, dc, es, nr);
      chk("rand_err", es, 0);
      chk("rand_reads", nr, len * tiles);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
